video_stream_capture: RTL

- Simulation-side and FPGA-side video capture block. Samples the core's pixel bus on a pixel-clock enable and expands RGB of any bit depth to ARGB8888.
- Tags start-of-frame and end-of-line, buffers pixels in a show-ahead FIFO, and presents them on a valid/ready stream to a display sink (DPI SDL window, scaler or framebuffer writer).
- Measures raster geometry (active width, active lines, frame count) for self-check.
- Sits between any arcade core's video outputs and the display sink.

---
 rtl/video_stream_capture.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/video_stream_capture.sv
// Video capture front end. It samples the core pixel bus on the pixel enable
// and expands RGB to ARGB8888. Each word is tagged with SOF/EOL, buffered in a
// show-ahead FIFO and offered on a valid/ready stream. The block also measures
// raster geometry.
module video_stream_capture #(
  parameter int R_BITS     = 3,
  parameter int G_BITS     = 3,
  parameter int B_BITS     = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int BLANK_MODE = 0,
  parameter int CNT_W      = 10
) (
  input  logic              Clk_I,
  input  logic              Reset_n,
  input  logic              Pix_En_I,
  input  logic [R_BITS-1:0] Red_I,
  input  logic [G_BITS-1:0] Green_I,
  input  logic [B_BITS-1:0] Blue_I,
  input  logic              HBlank_I,
  input  logic              VBlank_I,
  output logic [31:0]       Pix_Data_O,
  output logic              Pix_Sof_O,
  output logic              Pix_Eol_O,
  output logic              Pix_Valid_O,
  input  logic              Pix_Ready_I,
  input  logic              Ovf_Clr_I,
  output logic              Overflow_O,
  output logic [CNT_W-1:0]  Line_Width_O,
  output logic [CNT_W-1:0]  Frame_Lines_O,
  output logic [15:0]       Frame_Count_O
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [7:0]       w_r8, w_g8, w_b8;
  logic [31:0]      w_samp_data;
  logic             w_act_sample, w_active, w_vb_fall, w_vb_rise, w_sof_now;
  logic             w_push, w_push_eol, w_load, w_eol_geo;
  logic             w_valid, w_pop, w_full, w_wr, w_drop;
  logic [33:0]      w_head;
  logic [CNT_W-1:0] w_line_cnt_nx;

  logic             r_pend_valid, r_pend_sof, r_pend_hb, r_pend_act;
  logic [31:0]      r_pend_data;
  logic             r_vb_prev, r_vb_seen, r_sof_arm;
  logic [33:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic [CNT_W-1:0] r_pix_cnt, r_line_cnt, r_line_width, r_frame_lines;
  logic [15:0]      r_frame_cnt;

  // MSB-first bit replication of each channel to 8 bits
  for (genvar i = 0; i < 8; i++) begin : g_expand
    assign w_r8[7-i] = Red_I[R_BITS-1-(i % R_BITS)];
    assign w_g8[7-i] = Green_I[G_BITS-1-(i % G_BITS)];
    assign w_b8[7-i] = Blue_I[B_BITS-1-(i % B_BITS)];
  end

  assign w_act_sample = ~HBlank_I & ~VBlank_I;
  assign w_active     = Pix_En_I & w_act_sample;
  assign w_samp_data  = w_act_sample ? {8'hFF, w_r8, w_g8, w_b8} : '0;
  // A VBlank edge needs two samples, so the first sample after reset never counts as one
  assign w_vb_fall    = Pix_En_I & r_vb_seen & r_vb_prev & ~VBlank_I;
  assign w_vb_rise    = Pix_En_I & r_vb_seen & ~r_vb_prev & VBlank_I;
  assign w_sof_now    = w_act_sample & (r_sof_arm | w_vb_fall);

  // Pending-stage control: decide push, EOL tag and reload for this sample
  always_comb begin
    w_push     = Pix_En_I & r_pend_valid;
    w_load     = 1'b0;
    w_push_eol = 1'b0;
    if (BLANK_MODE != 0) begin
      w_load     = Pix_En_I;
      w_push_eol = HBlank_I & ~r_pend_hb;
    end else begin
      w_load     = w_active;
      w_push_eol = ~w_act_sample;
    end
  end

  // Geometry only follows lines whose last pixel was active (matters when blanking is streamed)
  assign w_eol_geo = w_push & w_push_eol & r_pend_act;

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & Pix_Ready_I;
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;
  assign w_head  = r_mem[r_rd_ptr];

  assign Pix_Valid_O   = w_valid;
  assign Pix_Data_O    = w_valid ? w_head[31:0] : '0;
  assign Pix_Eol_O     = w_valid & w_head[32];
  assign Pix_Sof_O     = w_valid & w_head[33];
  assign Overflow_O    = r_overflow;
  assign Line_Width_O  = r_line_width;
  assign Frame_Lines_O = r_frame_lines;
  assign Frame_Count_O = r_frame_cnt;

  // Pending register, VBlank edge tracking and SOF arming
  always_ff @(posedge Clk_I) begin
    if (!Reset_n) begin
      r_pend_valid <= 1'b0;
      r_pend_sof   <= 1'b0;
      r_pend_hb    <= 1'b0;
      r_pend_act   <= 1'b0;
      r_pend_data  <= '0;
      r_vb_prev    <= 1'b0;
      r_vb_seen    <= 1'b0;
      r_sof_arm    <= 1'b0;
    end else if (Pix_En_I) begin
      r_vb_prev <= VBlank_I;
      r_vb_seen <= 1'b1;
      r_sof_arm <= (r_sof_arm | w_vb_fall) & ~w_act_sample;
      if (w_load) begin
        r_pend_valid <= 1'b1;
        r_pend_sof   <= w_sof_now;
        r_pend_hb    <= HBlank_I;
        r_pend_act   <= w_act_sample;
        r_pend_data  <= w_samp_data;
      end else begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  // FIFO storage; contents are never read while the count is zero
  always_ff @(posedge Clk_I) begin
    if (w_wr) r_mem[r_wr_ptr] <= {r_pend_sof, w_push_eol, r_pend_data};
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge Clk_I) begin
    if (!Reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
      if (w_drop)         r_overflow <= 1'b1;
      else if (Ovf_Clr_I) r_overflow <= 1'b0;
    end
  end

  // Line count including an EOL pushed on the same sample as a VBlank rise
  always_comb begin
    w_line_cnt_nx = r_line_cnt;
    if (w_eol_geo && r_line_cnt != '1) w_line_cnt_nx = r_line_cnt + 1'b1;
  end

  // Raster geometry counters
  always_ff @(posedge Clk_I) begin
    if (!Reset_n) begin
      r_pix_cnt     <= '0;
      r_line_cnt    <= '0;
      r_line_width  <= '0;
      r_frame_lines <= '0;
      r_frame_cnt   <= '0;
    end else if (Pix_En_I) begin
      if (w_eol_geo) begin
        r_line_width <= r_pix_cnt;
        r_pix_cnt    <= '0;
      end else if (w_active && r_pix_cnt != '1) begin
        r_pix_cnt <= r_pix_cnt + 1'b1;
      end
      if (w_vb_rise) begin
        r_frame_lines <= w_line_cnt_nx;
        r_line_cnt    <= '0;
        r_frame_cnt   <= r_frame_cnt + 1'b1;
      end else begin
        r_line_cnt <= w_line_cnt_nx;
      end
    end
  end

endmodule
